fetch_decode_buffer: RTL and testbench
======================================

Name: fetch_decode_buffer

Overview:
- Two-entry elastic buffer between instruction fetch (IF) and decode (ID).
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Presents the head instruction, its PC, and the pre-sliced immediate field (instr[31:7]) to the decode stage and the immediate generator.
- Supports a pipeline flush for branch/jump redirects.

Parameters:
- XLEN, `XLEN_64b, 2-bit width code from riscv_defines.vh; datapath width W = 1<<(XLEN+4) (code 1 -> 32, code 2 -> 64).
- NOP_INSTR, 32'h0000_0013, instruction word driven on o_id_instr when no entry is valid (addi x0,x0,0).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_flush  input  1  synchronous flush; discards all entries and the incoming beat.
- i_if_valid  input  1  fetch presents an instruction.
- o_if_ready  output  1  buffer can accept a beat this cycle.
- i_if_instr  input  32  fetched instruction word.
- i_if_pc  input  W  PC of the fetched instruction.
- o_id_valid  output  1  head entry valid.
- i_id_ready  input  1  decode consumes the head this cycle.
- o_id_instr  output  32  head instruction, or NOP_INSTR when empty.
- o_id_pc  output  W  head PC, or 0 when empty.
- o_id_imm_bits  output  25  o_id_instr[31:7]; feeds the immediate generator.
- o_id_opcode  output  7  o_id_instr[6:0].
- o_count  output  2  occupancy, 0..2.

Behaviour:
- Reset: asynchronous on i_rst high. Occupancy is 0, read and write pointers are 0, and both storage entries are cleared to NOP_INSTR / PC 0.
  - Outputs during and after reset: o_id_valid=0, o_if_ready=1, o_count=0, o_id_instr=NOP_INSTR, o_id_pc=0, o_id_imm_bits=25'h000000, o_id_opcode=7'h13.
  - Reset asserted mid-transfer drops all content. No beat is accepted while i_rst is high.
- Storage: 2-entry circular buffer with 1-bit read and write pointers that wrap 1->0. Occupancy is held in a register, not derived from the pointers.
- Push: occurs when i_if_valid && o_if_ready && !i_flush. The entry is written at wptr, and wptr then toggles.
- Pop: occurs when o_id_valid && i_id_ready && !i_flush. rptr toggles.
- Ready: o_if_ready = (count != 2). It is a registered-state decode only, with no combinational path from i_id_ready.
  - When full, a pop in the same cycle does not open the input side. o_if_ready rises the cycle after the pop.
- Output valid and data: o_id_valid = (count != 0).
  - Outputs are driven from the entry at rptr. When count==0 they show NOP_INSTR / PC 0.
  - o_id_imm_bits and o_id_opcode are slices of o_id_instr.
- Latency: a beat pushed at edge N is visible on the outputs after edge N when the buffer was empty, giving 1-cycle IF->ID latency.
  - Order is strictly FIFO.
- Simultaneous push and pop with count==1: count stays 1, the head advances to the new entry, and no data is lost.
- Simultaneous push and pop with count==0: no pop, because o_id_valid=0. Count becomes 1.
- Flush:
  - Flush has priority over push and pop in the same cycle.
  - Next state: count=0, rptr=wptr=0, o_id_valid=0 on the following cycle.
  - The beat offered during the flush cycle is dropped, and fetch sees it as accepted if o_if_ready was 1.
  - Storage contents need not be cleared, but outputs must show NOP_INSTR / PC 0 while empty.
- Width: the PC is stored at full W bits with no truncation. The top PC bit must round-trip unchanged.
- Handshake stability: this block holds o_id_* stable while o_id_valid && !i_id_ready. The upstream stage holds i_if_* under stall, but this block does not depend on that.

Test Plan:
- Reset then idle -> o_id_valid=0, o_if_ready=1, o_count=0, o_id_instr=32'h00000013, o_id_imm_bits=0.
- Push instr 32'hFFF00093 at PC 64'h1000 with i_id_ready=0 -> next cycle o_id_valid=1, o_id_pc=64'h1000, o_id_imm_bits=25'h1FFE001, o_id_opcode=7'h13, o_count=1.
- Push two beats (PC 0x0, 0x4) with i_id_ready=0 -> o_count=2, o_if_ready=0. A third beat offered is not accepted.
  - Then pulse i_id_ready for one cycle -> head becomes PC 0x4, o_if_ready=1 the next cycle.
- Continuous stream of PCs 0x0, 0x4, 0x8, ... with i_id_ready=1 -> one instruction per cycle, in order, o_count stays 1, and the pointer wrap is exercised across at least 4 beats.
- Buffer full, then i_flush=1 together with i_if_valid=1 and i_id_ready=1 -> next cycle o_count=0, o_id_valid=0, o_id_instr=NOP. The flushed-cycle beat never appears.
- i_rst asserted asynchronously between clock edges while count=2 -> outputs return immediately to reset values. After release, a push of PC 64'h8000_0000_0000_0000 round-trips unchanged.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// Two-entry elastic buffer between instruction fetch and decode.
// Ready and valid both decode registered occupancy, so neither side sees a combinational path from the other.
module fetch_decode_buffer #(
  parameter int          XLEN      = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int         W         = 32'd1 << (XLEN + 32'd4)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_if_valid,
  output logic          o_if_ready,
  input  logic [31:0]   i_if_instr,
  input  logic [W-1:0]  i_if_pc,
  output logic          o_id_valid,
  input  logic          i_id_ready,
  output logic [31:0]   o_id_instr,
  output logic [W-1:0]  o_id_pc,
  output logic [24:0]   o_id_imm_bits,
  output logic [6:0]    o_id_opcode,
  output logic [1:0]    o_count
);

  logic [31:0]  instr_r [2];
  logic [W-1:0] pc_r    [2];
  logic         rptr_r;
  logic         wptr_r;
  logic [1:0]   count_r;
  logic         push_s;
  logic         pop_s;

  assign o_if_ready = (count_r != 2'd2);
  assign o_id_valid = (count_r != 2'd0);
  assign o_count    = count_r;

  // Flush suppresses both handshakes; a beat offered during flush is silently dropped.
  assign push_s = i_if_valid && o_if_ready && !i_flush;
  assign pop_s  = o_id_valid && i_id_ready && !i_flush;

  // Pointer and occupancy state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (i_flush) begin
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        wptr_r <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; full-width PC is kept so the top bit survives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        instr_r[i] <= NOP_INSTR;
        pc_r[i]    <= {W{1'b0}};
      end
    end else if (push_s) begin
      instr_r[wptr_r] <= i_if_instr;
      pc_r[wptr_r]    <= i_if_pc;
    end
  end

  // Head presentation; an empty buffer shows a NOP so stale storage never leaks out.
  always_comb begin
    o_id_instr = NOP_INSTR;
    o_id_pc    = {W{1'b0}};
    if (o_id_valid) begin
      o_id_instr = instr_r[rptr_r];
      o_id_pc    = pc_r[rptr_r];
    end else begin
      o_id_instr = NOP_INSTR;
      o_id_pc    = {W{1'b0}};
    end
  end

  assign o_id_imm_bits = o_id_instr[31:7];
  assign o_id_opcode   = o_id_instr[6:0];

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer (64-bit PC configuration).
module tb_fetch_decode_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_if_valid = 1'b0;
  logic        o_if_ready;
  logic [31:0] i_if_instr = 32'h0;
  logic [63:0] i_if_pc = 64'h0;
  logic        o_id_valid;
  logic        i_id_ready = 1'b0;
  logic [31:0] o_id_instr;
  logic [63:0] o_id_pc;
  logic [24:0] o_id_imm_bits;
  logic [6:0]  o_id_opcode;
  logic [1:0]  o_count;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_decode_buffer #(.XLEN(2), .NOP_INSTR(32'h0000_0013)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_if_valid    (i_if_valid),
    .o_if_ready    (o_if_ready),
    .i_if_instr    (i_if_instr),
    .i_if_pc       (i_if_pc),
    .o_id_valid    (o_id_valid),
    .i_id_ready    (i_id_ready),
    .o_id_instr    (o_id_instr),
    .o_id_pc       (o_id_pc),
    .o_id_imm_bits (o_id_imm_bits),
    .o_id_opcode   (o_id_opcode),
    .o_count       (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, " valid"}, 64'(o_id_valid), 64'd0);
    check({tag, " ready"}, 64'(o_if_ready), 64'd1);
    check({tag, " count"}, 64'(o_count), 64'd0);
    check({tag, " instr"}, 64'(o_id_instr), 64'(NOP));
    check({tag, " pc"}, o_id_pc, 64'd0);
    check({tag, " imm"}, 64'(o_id_imm_bits), 64'd0);
    check({tag, " opcode"}, 64'(o_id_opcode), 64'h13);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic rdy);
    i_if_valid = v;
    i_if_instr = ins;
    i_if_pc    = pc;
    i_id_ready = rdy;
  endtask

  initial begin
    // Reset, with a beat offered that must not be taken.
    i_rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 64'h40, 1'b0);
    step();
    step();
    check_empty("in_reset");
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    i_rst = 1'b0;
    step();
    check_empty("idle");

    // Single push, decode stalled.
    drive(1'b1, 32'hFFF0_0093, 64'h1000, 1'b0);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    check("push1 valid", 64'(o_id_valid), 64'd1);
    check("push1 pc", o_id_pc, 64'h1000);
    check("push1 imm", 64'(o_id_imm_bits), 64'h1FF_E001);
    check("push1 opcode", 64'(o_id_opcode), 64'h13);
    check("push1 count", 64'(o_count), 64'd1);
    step();
    check("push1 hold pc", o_id_pc, 64'h1000);
    i_id_ready = 1'b1;
    step();
    i_id_ready = 1'b0;
    check("pop1 count", 64'(o_count), 64'd0);

    // Fill to two, refuse a third, then single pop.
    drive(1'b1, 32'h0010_0093, 64'h0, 1'b0);
    step();
    drive(1'b1, 32'h0020_0113, 64'h4, 1'b0);
    step();
    check("full count", 64'(o_count), 64'd2);
    check("full ready", 64'(o_if_ready), 64'd0);
    check("full head pc", o_id_pc, 64'h0);
    drive(1'b1, 32'h0030_0193, 64'h8, 1'b0);
    step();
    check("third refused count", 64'(o_count), 64'd2);
    check("third refused head", 64'(o_id_instr), 64'h0010_0093);
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    step();
    check("after pop pc", o_id_pc, 64'h4);
    check("after pop instr", 64'(o_id_instr), 64'h0020_0113);
    check("after pop ready", 64'(o_if_ready), 64'd1);
    check("after pop count", 64'(o_count), 64'd1);
    step();
    check("drained count", 64'(o_count), 64'd0);

    // Streaming at full rate across several pointer wraps.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, {12'(i + 1), 20'h00093}, 64'(i * 4), 1'b1);
      step();
      check("stream pc", o_id_pc, 64'(i * 4));
      check("stream instr", 64'(o_id_instr), 64'({12'(i + 1), 20'h00093}));
      check("stream count", 64'(o_count), 64'd1);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    step();
    check("stream end count", 64'(o_count), 64'd0);

    // Flush while full with a beat and a pop offered.
    drive(1'b1, 32'h0040_0213, 64'h20, 1'b0);
    step();
    drive(1'b1, 32'h0050_0293, 64'h24, 1'b0);
    step();
    check("pre flush count", 64'(o_count), 64'd2);
    drive(1'b1, 32'h0060_0313, 64'h28, 1'b1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    check_empty("flush");
    step();
    check("flush stays empty", 64'(o_count), 64'd0);
    drive(1'b1, 32'h0070_0393, 64'h30, 1'b0);
    step();
    check("post flush head", o_id_pc, 64'h30);
    drive(1'b1, 32'h0080_0413, 64'h34, 1'b0);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    check("refill count", 64'(o_count), 64'd2);

    // Asynchronous reset between edges while full.
    #3;
    i_rst = 1'b1;
    #1;
    check_empty("async rst");
    step();
    i_rst = 1'b0;
    drive(1'b1, 32'h0090_0493, 64'h8000_0000_0000_0000, 1'b0);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    check("msb pc", o_id_pc, 64'h8000_0000_0000_0000);
    check("msb instr", 64'(o_id_instr), 64'h0090_0493);
    check("msb count", 64'(o_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
